// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared widths and lock-FSM state encoding for the data-memory arbiter
package dm_arbiter_pkg;
  localparam int DM_ADDR_W = 12;
  localparam int DM_DATA_W = 64;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} arb_state_e;
endpackage

// File: rtl/dm_arb_grant.sv
// dm_arb_grant: round-robin grant with bounded lock ownership
module dm_arb_grant
  import dm_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic lock0,
  input  logic lock1,
  output logic gnt0,
  output logic gnt1
);
  localparam int CW = $clog2(MAX_LOCK);
  localparam logic [CW-1:0] CMAX = CW'(MAX_LOCK - 1);
  arb_state_e state_q;
  logic last_q;
  logic [CW-1:0] cnt_q;
  always_comb begin
    gnt0 = rst_n & (state_q == OWN0 ? req0 : state_q == IDLE & req0 & (~req1 | last_q));
    gnt1 = rst_n & (state_q == OWN1 ? req1 : state_q == IDLE & req1 & (~req0 | ~last_q));
  end
  // lock_cnt counts cycles in ownership, so an idle owner still gets evicted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      if (gnt0 | gnt1) last_q <= gnt1;
      case (state_q)
        IDLE: begin
          if (gnt0 & lock0) begin
            state_q <= OWN0;
            cnt_q   <= CW'(1);
          end else if (gnt1 & lock1) begin
            state_q <= OWN1;
            cnt_q   <= CW'(1);
          end
        end
        OWN0: begin
          if (!lock0) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CMAX && req1) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
          end else cnt_q <= cnt_q == CMAX ? cnt_q : cnt_q + CW'(1);
        end
        OWN1: begin
          if (!lock1) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CMAX && req0) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
          end else cnt_q <= cnt_q == CMAX ? cnt_q : cnt_q + CW'(1);
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter onto a single-port data memory with registered read return
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DM_ADDR_W,
  parameter int DATA_W   = DM_DATA_W,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  output logic              dm_cs,
  input  logic [DATA_W-1:0] dm_rdata
);
  logic rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  dm_arb_grant #(.MAX_LOCK(MAX_LOCK)) u_grant (
    .clk  (clk),
    .rst_n(rst_n),
    .req0 (req0),
    .req1 (req1),
    .lock0(lock0),
    .lock1(lock1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );
  always_comb begin
    dm_cs    = gnt0 | gnt1;
    dm_we    = gnt0 ? we0 : gnt1 & we1;
    dm_addr  = gnt0 ? addr0 : gnt1 ? addr1 : '0;
    dm_wdata = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
      if (gnt0 & ~we0) rdata0_q <= dm_rdata;
      if (gnt1 & ~we1) rdata1_q <= dm_rdata;
    end
  end
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: table-driven and directed checks of dm_arbiter against a behavioural memory
module tb_dm_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [11:0] addr0 = '0, addr1 = '0;
  logic [63:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, dm_we, dm_cs;
  logic [63:0] rdata0, rdata1, dm_wdata, dm_rdata;
  logic [11:0] dm_addr;
  logic [63:0] mem [4096];
  int ncmp = 0, nbad = 0;
  typedef struct {
    logic r0, r1, w0, w1, l0, l1;
    logic [11:0] a0, a1;
    logic [63:0] d0, d1;
    logic g0, g1, cs, we;
    logic [11:0] ea;
    logic v0, v1;
    logic [63:0] q0, q1;
  } vec_t;
  vec_t tv [13];
  always #5 clk = ~clk;
  dm_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_cs(dm_cs), .dm_rdata(dm_rdata)
  );
  always @(posedge clk) if (dm_cs && dm_we) mem[dm_addr] <= dm_wdata;
  assign dm_rdata = mem[dm_addr];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    ncmp++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    tv[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 12'h000,12'h000, 64'h0,64'h0,     1'b0,1'b0,1'b0,1'b0, 12'h000, 1'b0,1'b0, 64'h0,64'h0};
    tv[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 12'h010,12'h000, 64'hA5A5,64'h0,  1'b1,1'b0,1'b1,1'b1, 12'h010, 1'b0,1'b0, 64'h0,64'h0};
    tv[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 12'h000,12'h010, 64'h0,64'h0,     1'b0,1'b1,1'b1,1'b0, 12'h010, 1'b0,1'b0, 64'h0,64'h0};
    tv[3]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 12'h000,12'h020, 64'h0,64'hBEEF,  1'b0,1'b1,1'b1,1'b1, 12'h020, 1'b0,1'b1, 64'h0,64'hA5A5};
    tv[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 12'h010,12'h020, 64'h0,64'h0,     1'b1,1'b0,1'b1,1'b0, 12'h010, 1'b0,1'b0, 64'h0,64'hA5A5};
    tv[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 12'h010,12'h020, 64'h0,64'h0,     1'b0,1'b1,1'b1,1'b0, 12'h020, 1'b1,1'b0, 64'hA5A5,64'hA5A5};
    tv[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 12'h010,12'h020, 64'h0,64'h0,     1'b1,1'b0,1'b1,1'b0, 12'h010, 1'b0,1'b1, 64'hA5A5,64'hBEEF};
    tv[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 12'h010,12'h020, 64'h0,64'h0,     1'b0,1'b1,1'b1,1'b0, 12'h020, 1'b1,1'b0, 64'hA5A5,64'hBEEF};
    tv[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 12'h000,12'h000, 64'h0,64'h0,     1'b0,1'b0,1'b0,1'b0, 12'h000, 1'b0,1'b1, 64'hA5A5,64'hBEEF};
    tv[9]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 12'h000,12'hFFF, 64'h0,64'h1,     1'b0,1'b1,1'b1,1'b1, 12'hFFF, 1'b0,1'b0, 64'hA5A5,64'hBEEF};
    tv[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 12'hFFF,12'h010, 64'h0,64'h0,     1'b1,1'b0,1'b1,1'b0, 12'hFFF, 1'b0,1'b0, 64'hA5A5,64'hBEEF};
    tv[11] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 12'h000,12'h010, 64'h0,64'h0,     1'b0,1'b1,1'b1,1'b0, 12'h010, 1'b1,1'b0, 64'h1,64'hBEEF};
    tv[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 12'h000,12'h000, 64'h0,64'h0,     1'b0,1'b0,1'b0,1'b0, 12'h000, 1'b0,1'b1, 64'h1,64'hA5A5};
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cyc();
      req0 = tv[i].r0; req1 = tv[i].r1; we0 = tv[i].w0; we1 = tv[i].w1;
      lock0 = tv[i].l0; lock1 = tv[i].l1; addr0 = tv[i].a0; addr1 = tv[i].a1;
      wdata0 = tv[i].d0; wdata1 = tv[i].d1;
      #3;
      chk($sformatf("row%0d gnt0", i), gnt0, tv[i].g0);
      chk($sformatf("row%0d gnt1", i), gnt1, tv[i].g1);
      chk($sformatf("row%0d dm_cs", i), dm_cs, tv[i].cs);
      chk($sformatf("row%0d dm_we", i), dm_we, tv[i].we);
      chk($sformatf("row%0d dm_addr", i), dm_addr, tv[i].ea);
      chk($sformatf("row%0d rvalid0", i), rvalid0, tv[i].v0);
      chk($sformatf("row%0d rvalid1", i), rvalid1, tv[i].v1);
      chk($sformatf("row%0d rdata0", i), rdata0, tv[i].q0);
      chk($sformatf("row%0d rdata1", i), rdata1, tv[i].q1);
    end
    for (int i = 0; i < 9; i++) begin
      cyc();
      req0 = 1'b1; req1 = 1'b1; lock0 = 1'b1; addr0 = 12'h010; addr1 = 12'h020;
      #3;
      chk($sformatf("lock c%0d gnt0", i), gnt0, i < 8);
      chk($sformatf("lock c%0d gnt1", i), gnt1, i == 8);
      chk($sformatf("lock c%0d rvalid0", i), rvalid0, i >= 1);
    end
    cyc();
    idle_in();
    #3;
    chk("lock end rvalid1", rvalid1, 1'b1);
    chk("lock end rdata1", rdata1, 64'hBEEF);
    cyc();
    req0 = 1'b1; lock0 = 1'b1; addr0 = 12'h010;
    #3;
    chk("own0 entry gnt0", gnt0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      req0 = 1'b0; lock0 = i < 3; req1 = 1'b1; addr1 = 12'h020;
      #3;
      chk($sformatf("own0 idle c%0d gnt0", i), gnt0, 1'b0);
      chk($sformatf("own0 idle c%0d gnt1", i), gnt1, 1'b0);
      chk($sformatf("own0 idle c%0d dm_cs", i), dm_cs, 1'b0);
    end
    cyc();
    #3;
    chk("own0 release gnt1", gnt1, 1'b1);
    chk("own0 release dm_addr", dm_addr, 12'h020);
    cyc();
    idle_in();
    req0 = 1'b1; addr0 = 12'h010;
    #3;
    chk("pre-reset read gnt0", gnt0, 1'b1);
    cyc();
    req0 = 1'b0;
    #3;
    chk("pre-reset rvalid0", rvalid0, 1'b1);
    chk("pre-reset rdata0", rdata0, 64'hA5A5);
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr1 = 12'h010;
    #1;
    chk("in-reset rvalid0", rvalid0, 1'b0);
    chk("in-reset rdata0", rdata0, 64'h0);
    chk("in-reset rdata1", rdata1, 64'h0);
    chk("in-reset gnt0", gnt0, 1'b0);
    chk("in-reset gnt1", gnt1, 1'b0);
    chk("in-reset dm_cs", dm_cs, 1'b0);
    cyc();
    rst_n = 1'b1;
    #3;
    chk("post-reset tie gnt0", gnt0, 1'b1);
    chk("post-reset tie gnt1", gnt1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
